// File: rtl/bcd_seq_alu_if.sv
// bcd_seq_alu_if: start/busy/done operand and result bundle for the BCD sequential ALU
interface bcd_seq_alu_if #(parameter int DIGIT_NUM = 8);
  logic                   start;
  logic [2:0]             operation;
  logic [4*DIGIT_NUM-1:0] operand0;
  logic                   operand0_sign;
  logic [4*DIGIT_NUM-1:0] operand1;
  logic                   operand1_sign;
  logic                   busy;
  logic                   done;
  logic [4*DIGIT_NUM-1:0] result;
  logic                   result_sign;
  logic                   flag_ov;
  logic                   flag_dz;
  logic                   flag_zero;
  modport master (
    output start, operation, operand0, operand0_sign, operand1, operand1_sign,
    input  busy, done, result, result_sign, flag_ov, flag_dz, flag_zero
  );
  modport slave (
    input  start, operation, operand0, operand0_sign, operand1, operand1_sign,
    output busy, done, result, result_sign, flag_ov, flag_dz, flag_zero
  );
endinterface

// File: rtl/bcd_seq_alu.sv
// bcd_seq_alu: multi-cycle signed-magnitude packed-BCD add/sub/mul/div
module bcd_seq_alu #(parameter int DIGIT_NUM = 8) (
  input logic         clk,
  input logic         rst,
  bcd_seq_alu_if.slave io
);
  localparam int W  = 4 * DIGIT_NUM;
  localparam int WX = W + 4;
  localparam int IW = $clog2(DIGIT_NUM + 1);
  typedef enum logic [2:0] {IDLE, ADDSUB, MUL_SHIFT, MUL_ADD, DIV_SHIFT, DIV_SUB, FINISH} state_t;
  state_t state, state_n;
  logic [W-1:0] a_q, b_q, acc, sh;
  logic [WX-1:0] rem, ax, bx, accx, sub_m, sub_s, sum, dif;
  logic [IW-1:0] idx;
  logic [3:0] cnt;
  logic sa, sb, sgn, ov, dz, arith, lt;
  // One extra guard digit lets the top digit act as carry/borrow indicator.
  function automatic logic [WX-1:0] badd(input logic [WX-1:0] x, input logic [WX-1:0] y, input logic ci);
    logic c;
    logic [4:0] s;
    logic [WX-1:0] r;
    c = ci;
    r = '0;
    for (int i = 0; i <= DIGIT_NUM; i++) begin
      s = 5'(x[4*i+:4]) + 5'(y[4*i+:4]) + 5'(c);
      c = s > 5'd9;
      r[4*i+:4] = c ? 4'(s + 5'd6) : s[3:0];
    end
    return r;
  endfunction
  function automatic logic [WX-1:0] nine(input logic [WX-1:0] x);
    logic [WX-1:0] r;
    for (int i = 0; i <= DIGIT_NUM; i++) r[4*i+:4] = 4'd9 - x[4*i+:4];
    return r;
  endfunction
  assign ax    = {4'b0, a_q};
  assign bx    = {4'b0, b_q};
  assign accx  = {4'b0, acc};
  assign lt    = a_q < b_q;
  assign sub_m = state == DIV_SUB ? rem : lt ? bx : ax;
  assign sub_s = state == DIV_SUB ? bx : lt ? ax : bx;
  assign dif   = badd(sub_m, nine(sub_s), 1'b1);
  assign sum   = badd(state == MUL_ADD ? accx : bx, ax, 1'b0);
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = !io.start ? IDLE : io.operation == 3'b010 ? MUL_SHIFT :
                           (io.operation == 3'b011 && io.operand1 != '0) ? DIV_SHIFT : ADDSUB;
      ADDSUB:    state_n = FINISH;
      MUL_SHIFT: state_n = idx == '0 ? FINISH : sh[W-1-:4] != 4'd0 ? MUL_ADD : MUL_SHIFT;
      MUL_ADD:   state_n = cnt == 4'd1 ? MUL_SHIFT : MUL_ADD;
      DIV_SHIFT: state_n = idx == '0 ? FINISH : DIV_SUB;
      DIV_SUB:   state_n = rem >= bx ? DIV_SUB : DIV_SHIFT;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      io.busy <= 1'b0;
      io.done <= 1'b0;
      io.result <= '0;
      io.result_sign <= 1'b0;
      io.flag_ov <= 1'b0;
      io.flag_dz <= 1'b0;
      io.flag_zero <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      sh <= '0;
      rem <= '0;
      idx <= '0;
      cnt <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      sgn <= 1'b0;
      ov <= 1'b0;
      dz <= 1'b0;
      arith <= 1'b0;
    end else begin
      io.done <= 1'b0;
      case (state)
        IDLE: if (io.start) begin
          a_q <= io.operand0;
          b_q <= io.operand1;
          sa <= io.operand0_sign;
          sb <= io.operand1_sign ^ (io.operation == 3'b001);
          sgn <= io.operand0_sign ^ io.operand1_sign;
          arith <= io.operation[2:1] == 2'b00;
          acc <= '0;
          rem <= '0;
          idx <= IW'(DIGIT_NUM);
          sh <= io.operation[0] ? io.operand0 : io.operand1;
          dz <= io.operation == 3'b011 && io.operand1 == '0;
          ov <= io.operation[2] || (io.operation == 3'b011 && io.operand1 == '0);
          io.busy <= 1'b1;
        end
        ADDSUB: if (arith) begin
          acc <= sa == sb ? sum[W-1:0] : dif[W-1:0];
          ov <= sa == sb && sum[WX-1-:4] != 4'd0;
          sgn <= sa ^ (sa != sb && lt);
        end
        MUL_SHIFT: if (idx != '0) begin
          acc <= acc << 4;
          ov <= ov | (acc[W-1-:4] != 4'd0);
          cnt <= sh[W-1-:4];
          sh <= sh << 4;
          idx <= idx - IW'(1);
        end
        MUL_ADD: begin
          acc <= sum[W-1:0];
          ov <= ov | (sum[WX-1-:4] != 4'd0);
          cnt <= cnt - 4'd1;
        end
        DIV_SHIFT: if (idx != '0) begin
          rem <= {rem[W-1:0], sh[W-1-:4]};
          acc <= acc << 4;
          sh <= sh << 4;
          idx <= idx - IW'(1);
        end
        DIV_SUB: if (rem >= bx) begin
          rem <= dif;
          acc <= acc + W'(1);
        end
        FINISH: begin
          io.result <= acc;
          io.result_sign <= sgn & (acc != '0);
          io.flag_zero <= acc == '0;
          io.flag_ov <= ov;
          io.flag_dz <= dz;
          io.done <= 1'b1;
          io.busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_seq_alu.sv
// tb_bcd_seq_alu: scoreboard bench for bcd_seq_alu with DIGIT_NUM=4 directed vectors
module tb_bcd_seq_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ndone = 0;
  typedef struct {
    string nm;
    logic [15:0] res;
    logic rs;
    logic ov;
    logic dz;
    logic zr;
    int lat;
    int acc;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  bcd_seq_alu_if #(.DIGIT_NUM(4)) io();
  bcd_seq_alu #(.DIGIT_NUM(4)) dut(.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst && io.done) begin
    ndone++;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
    end else begin
      e = sb.pop_front();
      chk({e.nm, ".result"}, 32'(io.result), 32'(e.res));
      chk({e.nm, ".sign"}, 32'(io.result_sign), 32'(e.rs));
      chk({e.nm, ".ov"}, 32'(io.flag_ov), 32'(e.ov));
      chk({e.nm, ".dz"}, 32'(io.flag_dz), 32'(e.dz));
      chk({e.nm, ".zero"}, 32'(io.flag_zero), 32'(e.zr));
      chk({e.nm, ".latency"}, 32'(cyc - e.acc), 32'(e.lat));
    end
  end
  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic as, input logic [15:0] b, input logic bs);
    io.start = 1'b1;
    io.operation = op;
    io.operand0 = a;
    io.operand0_sign = as;
    io.operand1 = b;
    io.operand1_sign = bs;
  endtask
  task automatic expect_op(input string nm, input logic [15:0] res, input logic rs, input logic ov,
                           input logic dz, input logic zr, input int lat);
    sb.push_back('{nm, res, rs, ov, dz, zr, lat, cyc + 1});
  endtask
  task automatic wait_drain(input string nm, input bit hammer);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
      io.start = hammer & io.busy;
      if (hammer) drive_garbage();
    end
    io.start = 1'b0;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: got no done in %0d cycles, expected done", nm, n);
      sb.delete();
    end
  endtask
  task automatic drive_garbage();
    io.operation = 3'b000;
    io.operand0 = 16'h9999;
    io.operand1 = 16'h1111;
    io.operand0_sign = 1'b1;
    io.operand1_sign = 1'b0;
  endtask
  task automatic run(input string nm, input logic [2:0] op, input logic [15:0] a, input logic as,
                     input logic [15:0] b, input logic bs, input logic [15:0] res, input logic rs,
                     input logic ov, input logic dz, input logic zr, input int lat);
    drive(op, a, as, b, bs);
    expect_op(nm, res, rs, ov, dz, zr, lat);
    @(negedge clk);
    io.start = 1'b0;
    wait_drain(nm, 1'b0);
  endtask
  initial begin
    int d0;
    io.start = 1'b0;
    io.operation = 3'b000;
    io.operand0 = '0;
    io.operand0_sign = 1'b0;
    io.operand1 = '0;
    io.operand1_sign = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.busy", 32'(io.busy), 0);
    chk("reset.done", 32'(io.done), 0);
    chk("reset.result", 32'(io.result), 0);
    chk("reset.flags", 32'({io.result_sign, io.flag_ov, io.flag_dz, io.flag_zero}), 0);
    rst = 1'b0;
    @(negedge clk);
    run("sum_mixed",  3'b000, 16'h0025, 0, 16'h0100, 1, 16'h0075, 1, 0, 0, 0, 2);
    run("sum_ovf",    3'b000, 16'h9999, 0, 16'h0001, 0, 16'h0000, 0, 1, 0, 1, 2);
    run("sub_zero",   3'b001, 16'h0005, 1, 16'h0005, 1, 16'h0000, 0, 0, 0, 1, 2);
    run("sub_neg",    3'b001, 16'h0030, 0, 16'h0100, 0, 16'h0070, 1, 0, 0, 0, 2);
    run("sum_negneg", 3'b000, 16'h0123, 1, 16'h0877, 1, 16'h1000, 1, 0, 0, 0, 2);
    run("mul_basic",  3'b010, 16'h0123, 0, 16'h0045, 1, 16'h5535, 1, 0, 0, 0, 15);
    run("mul_ovf",    3'b010, 16'h0100, 0, 16'h0100, 0, 16'h0000, 0, 1, 0, 1, 7);
    run("mul_zero",   3'b010, 16'h0000, 0, 16'h0009, 1, 16'h0000, 0, 0, 0, 1, 15);
    run("div_big",    3'b011, 16'h9999, 1, 16'h0007, 0, 16'h1428, 1, 0, 0, 0, 25);
    run("div_small",  3'b011, 16'h0010, 1, 16'h0003, 0, 16'h0003, 1, 0, 0, 0, 13);
    run("div_zero",   3'b011, 16'h0005, 0, 16'h0000, 0, 16'h0000, 0, 1, 1, 1, 2);
    run("bad_op",     3'b100, 16'h0012, 1, 16'h0034, 0, 16'h0000, 0, 1, 0, 1, 2);
    d0 = ndone;
    drive(3'b010, 16'h0123, 0, 16'h0045, 1);
    expect_op("mul_hammer", 16'h5535, 1, 0, 0, 0, 15);
    @(negedge clk);
    drive_garbage();
    io.start = io.busy;
    wait_drain("mul_hammer", 1'b1);
    repeat (5) @(negedge clk);
    chk("mul_hammer.done_count", 32'(ndone - d0), 1);
    run("div_prefill", 3'b011, 16'h9999, 0, 16'h0007, 1, 16'h1428, 1, 0, 0, 0, 25);
    drive(3'b011, 16'h9999, 1, 16'h0007, 0);
    @(negedge clk);
    io.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", 32'(io.busy), 0);
    chk("abort.done", 32'(io.done), 0);
    chk("abort.result", 32'(io.result), 0);
    chk("abort.flags", 32'({io.result_sign, io.flag_ov, io.flag_dz, io.flag_zero}), 0);
    run("div_after_rst", 3'b011, 16'h0100, 0, 16'h0007, 0, 16'h0014, 0, 0, 0, 0, 15);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
